ps2_key_ctrl: RTL and testbench

- Sits between the PS/2 byte receiver and the CPU-side keyboard MMIO.
- Takes validated scancode bytes (set 2) with a one-cycle strobe and sequences the E0/F0 prefix protocol into single key events.
- Tracks modifier and caps-lock state, and buffers events in a small FIFO that software drains with a valid/ready handshake.
- Drops stale prefixes on timeout and flags FIFO overflow.

---
 rtl/ps2_key_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// Generic single-clock FIFO; the head is read straight from storage.
// Latency: a push is visible at the head one cycle later.
// Backpressure: a push while full is refused unless a pop happens in the same cycle.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_vld,
    input  logic [W-1:0]           push_dat,
    output logic                   push_rdy,
    input  logic                   pop_rdy,
    output logic                   pop_vld,
    output logic [W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign pop_vld  = (count != '0);
    assign do_pop   = pop_vld & pop_rdy;
    assign push_rdy = (count != (AW+1)'(DEPTH)) | do_pop;
    assign do_push  = push_vld & push_rdy;
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + (AW+1)'(1);
            else if (!do_push && do_pop) count <= count - (AW+1)'(1);
        end
    end
endmodule

// PS/2 set-2 scancode sequencer: folds E0/F0 prefixes into key events, tracks modifiers/caps.
// Latency: byte strobed at edge N lands in the event FIFO (and updates modifiers) at edge N+1.
// Backpressure: none toward the receiver; events arriving at a full FIFO are dropped and flag ovf.
module ps2_key_ctrl #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   ev_valid,
    output logic [9:0]             ev_data,
    input  logic                   ev_ready,
    output logic                   shift,
    output logic                   ctrl,
    output logic                   alt,
    output logic                   caps,
    output logic                   ovf,
    input  logic                   ovf_clr,
    output logic [$clog2(DEPTH):0] count
);
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ev_t;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    localparam int            TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          emit_vld;
    ev_t           emit_dat;
    logic          fifo_rdy;
    logic          l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt, caps_held;

    function automatic logic is_silent(input logic [7:0] b);
        return (b == 8'hAA) || (b == 8'hFA) || (b == 8'hEE) ||
               (b == 8'hFE) || (b == 8'h00) || (b == 8'hFF);
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            tcnt     <= '0;
            emit_vld <= 1'b0;
            emit_dat <= '0;
        end else begin
            emit_vld <= 1'b0;
            if (rx_valid) begin
                tcnt <= '0;
                case (state)
                    IDLE: begin
                        if (rx_data == 8'hE0)      state <= EXT;
                        else if (rx_data == 8'hF0) state <= BRK;
                        else if (!is_silent(rx_data)) begin
                            emit_vld <= 1'b1;
                            emit_dat <= {1'b0, 1'b0, rx_data};
                        end
                    end
                    EXT: begin
                        if (rx_data == 8'hF0)      state <= EXT_BRK;
                        else if (rx_data == 8'hE0) state <= EXT;
                        else begin
                            emit_vld <= 1'b1;
                            emit_dat <= {1'b1, 1'b0, rx_data};
                            state    <= IDLE;
                        end
                    end
                    BRK: begin
                        // A second prefix after F0 is malformed; abandon the sequence.
                        if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                            emit_vld <= 1'b1;
                            emit_dat <= {1'b0, 1'b1, rx_data};
                        end
                        state <= IDLE;
                    end
                    EXT_BRK: begin
                        if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
                            emit_vld <= 1'b1;
                            emit_dat <= {1'b1, 1'b1, rx_data};
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state != IDLE) begin
                if (tcnt == T_LAST) begin
                    state <= IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + TW'(1);
                end
            end
        end
    end

    fifo #(.W($bits(ev_t)), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push_vld (emit_vld),
        .push_dat (emit_dat),
        .push_rdy (fifo_rdy),
        .pop_rdy  (ev_ready),
        .pop_vld  (ev_valid),
        .pop_dat  (ev_data),
        .count    (count)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                   ovf <= 1'b0;
        else if (emit_vld && !fifo_rdy) ovf <= 1'b1;
        else if (ovf_clr)              ovf <= 1'b0;
    end

    // Modifiers follow every emitted event, even one the FIFO drops, so key state never desyncs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            {l_shift, r_shift, l_ctrl, r_ctrl, l_alt, r_alt} <= '0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (emit_vld && !emit_dat.ext) begin
            case (emit_dat.code)
                8'h12: l_shift <= ~emit_dat.brk;
                8'h59: r_shift <= ~emit_dat.brk;
                8'h14: l_ctrl  <= ~emit_dat.brk;
                8'h11: l_alt   <= ~emit_dat.brk;
                8'h58: begin
                    if (emit_dat.brk) begin
                        caps_held <= 1'b0;
                    end else begin
                        if (!caps_held) caps <= ~caps;
                        caps_held <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (emit_vld) begin
            case (emit_dat.code)
                8'h14:   r_ctrl <= ~emit_dat.brk;
                8'h11:   r_alt  <= ~emit_dat.brk;
                default: ;
            endcase
        end
    end

    assign shift = l_shift | r_shift;
    assign ctrl  = l_ctrl | r_ctrl;
    assign alt   = l_alt | r_alt;
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl against a byte-stream reference model.
module tb_ps2_key_ctrl;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 10;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       ev_valid;
    logic [9:0] ev_data;
    logic       ev_ready = 1'b0;
    logic       shift, ctrl, alt, caps, ovf;
    logic       ovf_clr = 1'b0;
    logic [3:0] count;

    ps2_key_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .ev_valid (ev_valid),
        .ev_data  (ev_data),
        .ev_ready (ev_ready),
        .shift    (shift),
        .ctrl     (ctrl),
        .alt      (alt),
        .caps     (caps),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .count    (count)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of pending events, prefix flags, and a table of held keys.
    logic [9:0] mq[$];
    bit         st_v;
    logic [9:0] st_dat;
    bit         p_ext, p_brk;
    int         quiet;
    bit         held [512];
    bit         m_caps, m_ovf;

    function automatic bit m_shift(); return held[9'h012] | held[9'h059]; endfunction
    function automatic bit m_ctrl();  return held[9'h014] | held[9'h114]; endfunction
    function automatic bit m_alt();   return held[9'h011] | held[9'h111]; endfunction

    task automatic note_key(input logic [9:0] e);
        int key;
        key = int'({e[9], e[7:0]});
        if (!e[8] && key == 'h058 && !held[key]) m_caps = ~m_caps;
        held[key] = ~e[8];
    endtask

    task automatic take_byte(input logic [7:0] b);
        if (b == 8'hE0 || b == 8'hF0) begin
            if (p_brk) begin
                p_ext = 0;
                p_brk = 0;
            end else if (b == 8'hE0) p_ext = 1;
            else p_brk = 1;
        end else if (!p_ext && !p_brk && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
            st_v = 0;
        end else begin
            st_v   = 1;
            st_dat = {p_ext, p_brk, b};
            p_ext  = 0;
            p_brk  = 0;
        end
    endtask

    task automatic model_step();
        bit popped, dropped;
        popped  = ev_ready && (mq.size() > 0);
        dropped = 0;
        if (popped) void'(mq.pop_front());
        if (st_v) begin
            note_key(st_dat);
            if (mq.size() < DEPTH) mq.push_back(st_dat);
            else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
        st_v = 0;
        if (rx_valid) begin
            quiet = 0;
            take_byte(rx_data);
        end else if (p_ext || p_brk) begin
            quiet++;
            if (quiet >= TIMEOUT) begin
                p_ext = 0;
                p_brk = 0;
                quiet = 0;
            end
        end
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            st_v   = 0;
            st_dat = '0;
            p_ext  = 0;
            p_brk  = 0;
            quiet  = 0;
            m_caps = 0;
            m_ovf  = 0;
            for (int i = 0; i < 512; i++) held[i] = 0;
        end else begin
            model_step();
        end
    end

    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp && resetn) begin
            check("cmp_ev_valid", 32'(ev_valid), 32'(mq.size() != 0));
            check("cmp_count",    32'(count),    32'(mq.size()));
            if (mq.size() != 0) check("cmp_ev_data", 32'(ev_data), 32'(mq[0]));
            check("cmp_shift", 32'(shift), 32'(m_shift()));
            check("cmp_ctrl",  32'(ctrl),  32'(m_ctrl()));
            check("cmp_alt",   32'(alt),   32'(m_alt()));
            check("cmp_caps",  32'(caps),  32'(m_caps));
            check("cmp_ovf",   32'(ovf),   32'(m_ovf));
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pop1();
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && ev_valid; i++) pop1();
        check("drain_empty", 32'(ev_valid), 32'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_ev_valid", 32'(ev_valid), 32'(0));
        check("rst_count",    32'(count),    32'(0));
        check("rst_ev_data",  32'(ev_data),  32'(0));
        check("rst_mods",     32'({shift, ctrl, alt, caps}), 32'(0));
        check("rst_ovf",      32'(ovf),      32'(0));
        @(negedge clk);
        resetn  = 1'b1;
        run_cmp = 1;

        // Make / break
        send(8'h1C); send(8'hF0); send(8'h1C); idle(1);
        check("mb_count", 32'(count), 32'(2));
        check("mb_head0", 32'(ev_data), 32'h01C);
        pop1();
        check("mb_head1", 32'(ev_data), 32'h11C);
        pop1();
        check("mb_empty", 32'(ev_valid), 32'(0));

        // Extended make/break, then a malformed F0 E0
        send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75); idle(1);
        check("ext_head0", 32'(ev_data), 32'h275);
        pop1();
        check("ext_head1", 32'(ev_data), 32'h375);
        pop1();
        send(8'hF0); send(8'hE0); send(8'h1C); idle(1);
        check("stray_count", 32'(count), 32'(1));
        check("stray_head",  32'(ev_data), 32'h01C);
        drain();

        // Silent bytes in IDLE produce nothing
        send(8'hAA); send(8'hFA); send(8'h00); idle(1);
        check("silent_count", 32'(count), 32'(0));

        // Modifiers and caps
        send(8'h12); send(8'h59); send(8'hF0); send(8'h12); idle(1);
        check("shift_both", 32'(shift), 32'(1));
        send(8'hF0); send(8'h59); idle(1);
        check("shift_rel", 32'(shift), 32'(0));
        drain();
        send(8'hE0); send(8'h14); idle(1);
        check("rctrl", 32'(ctrl), 32'(1));
        check("rctrl_ev", 32'(ev_data), 32'h214);
        drain();
        send(8'h58); send(8'h58); send(8'hF0); send(8'h58); idle(1);
        check("caps_once", 32'(caps), 32'(1));
        drain();

        // Overflow
        for (int b = 'h15; b <= 'h1D; b++) send(8'(b));
        idle(1);
        check("ovf_count", 32'(count), 32'(8));
        check("ovf_flag",  32'(ovf),   32'(1));
        check("ovf_head",  32'(ev_data), 32'h015);
        send(8'h1E); pop1();
        check("full_pp_count", 32'(count), 32'(8));
        check("full_pp_head",  32'(ev_data), 32'h016);
        ovf_clr = 1'b1; @(negedge clk); ovf_clr = 1'b0;
        check("ovf_clr", 32'(ovf), 32'(0));
        drain();

        // Prefix timeout
        send(8'hE0); idle(20); send(8'h1C); idle(1);
        check("to_expired", 32'(ev_data), 32'h01C);
        drain();
        send(8'hE0); idle(4); send(8'h1C); idle(1);
        check("to_within", 32'(ev_data), 32'h21C);
        drain();

        // Asynchronous reset in the middle of a sequence
        send(8'h12); send(8'h1C); send(8'h2C); send(8'h3C); send(8'hF0);
        check("pre_rst_shift", 32'(shift), 32'(1));
        #2 resetn = 1'b0;
        #1;
        check("arst_ev_valid", 32'(ev_valid), 32'(0));
        check("arst_count",    32'(count),    32'(0));
        check("arst_mods",     32'({shift, ctrl, alt, caps}), 32'(0));
        #1 resetn = 1'b1;
        @(negedge clk);
        send(8'h1C); idle(1);
        check("post_rst_head",  32'(ev_data), 32'h01C);
        check("post_rst_count", 32'(count), 32'(1));
        drain();

        idle(2);
        run_cmp = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
